// File: rtl/demux_16_1_collect.sv
// rtl/demux_16_1_collect.sv - 1:N registered bit demultiplexer/collector with word handshake
// Steers serial bits into word positions and presents the completed word on dout.
module demux_16_1_collect #(
  parameter int SEL_W           = 4,
  parameter int ALLOW_OVERWRITE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic [SEL_W-1:0]     s,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 flush,
  output logic [(1<<SEL_W)-1:0] strb,
  output logic [SEL_W:0]       fill_cnt,
  output logic                 dup_err,
  output logic [(1<<SEL_W)-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  localparam int N = 1 << SEL_W;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   buf_q, buf_n;
  logic [N-1:0]   mask, mask_n;
  logic [N-1:0]   strb_n;
  logic [N-1:0]   dout_n;
  logic [N-1:0]   pos;
  logic [N-1:0]   word_w;
  logic [N-1:0]   mask_w;
  logic [SEL_W:0] fill_n;
  logic           dup_n;
  logic           valid_n;
  logic           dup_hit;

  function automatic logic [SEL_W:0] popcount(input logic [N-1:0] v);
    logic [SEL_W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{SEL_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign din_ready = (state == COLLECT);
  assign pos       = {{(N-1){1'b0}}, 1'b1} << s;
  assign dup_hit   = mask[s] && (ALLOW_OVERWRITE == 0);
  assign word_w    = din ? (buf_q | pos) : (buf_q & ~pos);
  assign mask_w    = mask | pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      buf_q      <= '0;
      mask       <= '0;
      strb       <= '0;
      fill_cnt   <= '0;
      dup_err    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_n;
      buf_q      <= buf_n;
      mask       <= mask_n;
      strb       <= strb_n;
      fill_cnt   <= fill_n;
      dup_err    <= dup_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    buf_n   = buf_q;
    mask_n  = mask;
    strb_n  = '0;
    dup_n   = 1'b0;
    dout_n  = dout;
    valid_n = dout_valid;
    case (state)
      COLLECT: begin
        // flush beats a same-cycle write: nothing of the write survives
        if (flush) begin
          buf_n  = '0;
          mask_n = '0;
        end else if (din_valid) begin
          if (dup_hit) begin
            dup_n = 1'b1;
          end else begin
            strb_n = pos;
            if (&mask_w) begin
              dout_n  = word_w;
              valid_n = 1'b1;
              buf_n   = '0;
              mask_n  = '0;
              state_n = FULL;
            end else begin
              buf_n  = word_w;
              mask_n = mask_w;
            end
          end
        end
      end
      FULL: begin
        if (dout_ready) begin
          valid_n = 1'b0;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
    fill_n = popcount(mask_n);
  end

endmodule

// File: tb/tb_demux_16_1_collect.sv
// tb/tb_demux_16_1_collect.sv - directed self-checking bench for demux_16_1_collect
module tb_demux_16_1_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [3:0]  s;
  logic        din_valid;
  logic        flush;
  logic        dout_ready;

  logic        din_ready, din_ready_b;
  logic [15:0] strb, strb_b;
  logic [4:0]  fill_cnt, fill_cnt_b;
  logic        dup_err, dup_err_b;
  logic [15:0] dout, dout_b;
  logic        dout_valid, dout_valid_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_16_1_collect #(.SEL_W(4), .ALLOW_OVERWRITE(0)) dut (
    .clk(clk), .rst(rst), .din(din), .s(s), .din_valid(din_valid),
    .din_ready(din_ready), .flush(flush), .strb(strb), .fill_cnt(fill_cnt),
    .dup_err(dup_err), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  demux_16_1_collect #(.SEL_W(4), .ALLOW_OVERWRITE(1)) dut_ow (
    .clk(clk), .rst(rst), .din(din), .s(s), .din_valid(din_valid),
    .din_ready(din_ready_b), .flush(flush), .strb(strb_b), .fill_cnt(fill_cnt_b),
    .dup_err(dup_err_b), .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready)
  );

  typedef struct {
    logic        d;
    logic [3:0]  pos;
    logic [15:0] exp_strb;
    logic [4:0]  exp_fill;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic d, input int p);
    din       = d;
    s         = 4'(p);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic fill_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) wr(w[i], i);
  endtask

  task automatic handshake();
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; s = '0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      vecs[i].d         = 1'(i % 2);
      vecs[i].pos       = 4'(i);
      vecs[i].exp_strb  = 16'(1 << i);
      vecs[i].exp_fill  = (i == 15) ? 5'd0 : 5'(i + 1);
      vecs[i].exp_valid = (i == 15);
    end

    // 1: reset state, then async reset mid-word
    #12;
    chk("rst_strb", 32'(strb), 32'h0);
    chk("rst_fill", 32'(fill_cnt), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    rst = 1'b0;
    step();
    chk("rst_din_ready", 32'(din_ready), 32'h1);
    for (int i = 0; i < 5; i++) wr(1'b1, i);
    chk("pre_rst_fill", 32'(fill_cnt), 32'd5);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_fill", 32'(fill_cnt), 32'h0);
    chk("async_rst_strb", 32'(strb), 32'h0);
    #2 rst = 1'b0;
    step();
    chk("post_rst_fill", 32'(fill_cnt), 32'h0);

    // 2: in-order fill from the vector table
    for (int i = 0; i < 16; i++) begin
      wr(vecs[i].d, int'(vecs[i].pos));
      chk($sformatf("t2_strb%0d", i), 32'(strb), 32'(vecs[i].exp_strb));
      chk($sformatf("t2_fill%0d", i), 32'(fill_cnt), 32'(vecs[i].exp_fill));
      chk($sformatf("t2_valid%0d", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
    end
    chk("t2_dout", 32'(dout), 32'hAAAA);
    chk("t2_ready_full", 32'(din_ready), 32'h0);
    handshake();
    chk("t2_valid_drop", 32'(dout_valid), 32'h0);
    chk("t2_ready_back", 32'(din_ready), 32'h1);
    chk("t2_dout_kept", 32'(dout), 32'hAAAA);

    // 3: reverse order, consumer stalls 4 clocks, writes and flush in FULL ignored
    for (int i = 15; i >= 0; i--) wr(1'b1, i);
    chk("t3_valid", 32'(dout_valid), 32'h1);
    for (int k = 0; k < 4; k++) begin
      din = 1'b0; s = 4'(k); din_valid = 1'b1; flush = (k == 2);
      step();
      chk($sformatf("t3_hold_dout%0d", k), 32'(dout), 32'hFFFF);
      chk($sformatf("t3_hold_valid%0d", k), 32'(dout_valid), 32'h1);
      chk($sformatf("t3_ready%0d", k), 32'(din_ready), 32'h0);
      chk($sformatf("t3_strb%0d", k), 32'(strb), 32'h0);
      chk($sformatf("t3_dup%0d", k), 32'(dup_err), 32'h0);
    end
    flush = 1'b0;
    handshake();
    din_valid = 1'b0;
    chk("t3_valid_drop", 32'(dout_valid), 32'h0);
    chk("t3_fill_empty", 32'(fill_cnt), 32'h0);

    // 4: duplicate write, drop vs overwrite
    wr(1'b1, 3);
    chk("t4_first_strb", 32'(strb), 32'h8);
    wr(1'b0, 3);
    chk("t4_dup_err", 32'(dup_err), 32'h1);
    chk("t4_dup_strb", 32'(strb), 32'h0);
    chk("t4_dup_fill", 32'(fill_cnt), 32'd1);
    chk("t4_ow_dup_err", 32'(dup_err_b), 32'h0);
    chk("t4_ow_strb", 32'(strb_b), 32'h8);
    chk("t4_ow_fill", 32'(fill_cnt_b), 32'd1);
    step();
    chk("t4_dup_pulse_end", 32'(dup_err), 32'h0);
    for (int i = 0; i < 16; i++) if (i != 3) wr(1'b0, i);
    chk("t4_valid", 32'(dout_valid), 32'h1);
    chk("t4_dout", 32'(dout), 32'h0008);
    chk("t4_ow_valid", 32'(dout_valid_b), 32'h1);
    chk("t4_ow_dout", 32'(dout_b), 32'h0000);
    handshake();

    // 5: flush colliding with a write at fill_cnt=7, then a clean word
    for (int i = 0; i < 7; i++) wr(1'b1, i);
    chk("t5_fill7", 32'(fill_cnt), 32'd7);
    flush = 1'b1;
    wr(1'b1, 7);
    flush = 1'b0;
    chk("t5_flush_fill", 32'(fill_cnt), 32'h0);
    chk("t5_flush_strb", 32'(strb), 32'h0);
    chk("t5_flush_dup", 32'(dup_err), 32'h0);
    fill_word(16'h1234);
    chk("t5_valid", 32'(dout_valid), 32'h1);
    chk("t5_dout", 32'(dout), 32'h1234);
    handshake();

    // 6: back-to-back words with the consumer always ready
    dout_ready = 1'b1;
    fill_word(16'h0F0F);
    chk("t6_w1_valid", 32'(dout_valid), 32'h1);
    chk("t6_w1_dout", 32'(dout), 32'h0F0F);
    step();
    chk("t6_w1_one_cycle", 32'(dout_valid), 32'h0);
    fill_word(16'hF00F);
    chk("t6_w2_valid", 32'(dout_valid), 32'h1);
    chk("t6_w2_dout", 32'(dout), 32'hF00F);
    step();
    chk("t6_w2_one_cycle", 32'(dout_valid), 32'h0);
    chk("t6_w2_kept", 32'(dout), 32'hF00F);
    dout_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
